// File: rtl/act_pkg.sv
// Shared Q4.12 types and constants for the activation-unit arbiter and its
// piecewise-linear activation datapath.
package act_pkg;

   typedef logic signed [15:0] q4_12_t;

   localparam q4_12_t Q_ONE       = 16'sd4096;
   localparam q4_12_t Q_MINUS_ONE = -16'sd4096;
   localparam q4_12_t Q_HALF      = 16'sd2048;

   // Source-ID width: enough bits to name every requester, never zero.
   function automatic int id_width(input int n);
      return ($clog2(n) > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/act_unit_arbiter_if.sv
// Handshake bundle between the streaming requesters, the shared activation
// arbiter and the downstream result consumer.
interface act_unit_arbiter_if
   import act_pkg::*;
#(
   parameter int NUM_REQ = 4
);
   localparam int ID_W = id_width(NUM_REQ);

   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ*16-1:0] req_data;
   logic [NUM_REQ-1:0]    req_last;
   logic [NUM_REQ-1:0]    req_ready;
   logic                  out_valid;
   logic                  out_ready;
   q4_12_t                out_data;
   logic [ID_W-1:0]       out_id;
   logic                  out_last;
   logic                  busy;

   modport master (
      output req_valid, req_data, req_last, out_ready,
      input  req_ready, out_valid, out_data, out_id, out_last, busy
   );

   modport slave (
      input  req_valid, req_data, req_last, out_ready,
      output req_ready, out_valid, out_data, out_id, out_last, busy
   );

endinterface

// File: rtl/pwl_activation.sv
// Hard-tanh in Q4.12: doubles the input and saturates to +/-1.0.
module pwl_activation
   import act_pkg::*;
(
   input  q4_12_t x,
   output q4_12_t y
);

   // Inside (-0.5, +0.5) the doubled value always fits in Q4.12.
   always_comb begin
      if (x <= -Q_HALF)
         y = Q_MINUS_ONE;
      else if (x >= Q_HALF)
         y = Q_ONE;
      else
         y = x <<< 1;
   end

endmodule

// File: rtl/act_unit_arbiter.sv
// Round-robin, packet-locked arbiter sharing one hard-tanh datapath between
// NUM_REQ streaming requesters through a 2-stage backpressured pipeline.
module act_unit_arbiter
   import act_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 16
)(
   input logic               clk,
   input logic               rst,
   act_unit_arbiter_if.slave bus
);

   localparam int ID_W = id_width(NUM_REQ);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t              state;
   logic [ID_W-1:0]     rr_ptr, owner, winner, cand, grant;
   logic                any_req, grant_valid, hs;
   logic                s1_can_load, s2_advance;
   logic                s1_valid, s1_last;
   logic [ID_W-1:0]     s1_id, out_id_q;
   q4_12_t              s1_data, act_y, out_data_q, grant_data;
   logic                out_valid_q, out_last_q;
   logic [NUM_REQ-1:0]  req_ready;
   logic [DATA_W-1:0]   lane [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
      assign lane[i] = bus.req_data[i*DATA_W +: DATA_W];
   end

   // First valid requester after the last winner, wrapping around.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      winner  = '0;
      cand    = '0;
      any_req = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!any_req && bus.req_valid[cand]) begin
            winner  = cand;
            any_req = 1'b1;
         end
      end
   end

   assign grant       = (state == LOCKED) ? owner : winner;
   assign grant_valid = (state == LOCKED) | any_req;
   assign s2_advance  = !out_valid_q | bus.out_ready;
   assign s1_can_load = !s1_valid | s2_advance;
   assign hs          = grant_valid & s1_can_load & bus.req_valid[grant];
   assign grant_data  = q4_12_t'(lane[grant]);

   // Ready is masked by reset so it drops the instant reset asserts.
   always_comb begin
      req_ready = '0;
      if (!rst && grant_valid)
         req_ready[grant] = s1_can_load;
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state  <= IDLE;
         rr_ptr <= ID_W'(NUM_REQ - 1);
         owner  <= '0;
      end else if (hs) begin
         if (state == IDLE) begin
            rr_ptr <= winner;
            if (!bus.req_last[grant]) begin
               state <= LOCKED;
               owner <= winner;
            end
         end else if (bus.req_last[grant]) begin
            state <= IDLE;
         end
      end
   end

   pwl_activation u_act (
      .x (s1_data),
      .y (act_y)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid    <= 1'b0;
         s1_data     <= '0;
         s1_id       <= '0;
         s1_last     <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= '0;
         out_last_q  <= 1'b0;
      end else begin
         if (s1_can_load) begin
            s1_valid <= hs;
            if (hs) begin
               s1_data <= grant_data;
               s1_id   <= grant;
               s1_last <= bus.req_last[grant];
            end
         end
         // Stage 2 only moves when downstream frees it, so a stalled beat stays frozen.
         if (s2_advance) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
               out_data_q <= act_y;
               out_id_q   <= s1_id;
               out_last_q <= s1_last;
            end
         end
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_id    = out_id_q;
   assign bus.out_last  = out_last_q;
   assign bus.busy      = (state == LOCKED) | s1_valid | out_valid_q;

endmodule

// File: doc/act_unit_arbiter.md
Name: act_unit_arbiter

Overview:
- Round-robin arbiter and pipeline sequencer that shares one PWL activation datapath (Q4.12 hard-tanh: y=2x, clamped to ±1.0) between NUM_REQ streaming requesters, e.g. parallel conv-channel outputs in the HiFi-GAN generator.
- Grants one requester per packet and locks until that requester's last beat.
- Pushes beats through a 2-stage registered pipeline with full backpressure.
- Tags each result with the source ID for return routing.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 16, sample width; fixed Q4.12 signed, must be 16.
- ID_W, derived localparam = max(1, clog2(NUM_REQ)), width of the source ID.

Ports:
- clk  in  1  single clock; all state is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_data  in  NUM_REQ*16  packed Q4.12 samples; requester i occupies bits [16i+15:16i].
- req_last  in  NUM_REQ  final beat of the requester's packet.
- req_ready  out  NUM_REQ  beat accepted when req_valid[i] & req_ready[i].
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result beat.
- out_data  out  16  activated Q4.12 result, range [-4096, 4096].
- out_id  out  ID_W  requester index that produced the beat.
- out_last  out  1  forwarded req_last of the beat.
- busy  out  1  high if the arbiter is LOCKED or any pipeline stage is valid.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, rr_ptr=NUM_REQ-1.
  - s1_valid=0, out_valid=0, out_data=0, out_id=0, out_last=0, req_ready=0, busy=0.
- Arbiter FSM:
  - IDLE:
    - Combinational round-robin pick over req_valid, searching from rr_ptr+1 upward with wrap; winner w.
    - req_ready[w] = s1_can_load; all other req_ready bits are 0.
    - On handshake with req_last=0: go to LOCKED, owner=w.
    - On handshake with req_last=1: stay IDLE.
    - On any handshake: rr_ptr<=w.
    - No requests pending: no change.
  - LOCKED:
    - req_ready[owner] = s1_can_load; all other requesters are blocked even when valid.
    - Stay LOCKED until an owner handshake with req_last=1, then go to IDLE.
    - Owner dropping req_valid mid-packet holds the lock (bubble only); no timeout.
- Pipeline:
  - s1_can_load = !s1_valid | s2_advance.
  - s2_advance = !out_valid | out_ready.
  - Stage 1 captures data, ID and last on handshake.
  - Stage 2 loads the activation of the stage-1 data when s1_valid & s2_advance.
  - Stage 2 holds all outputs stable while out_valid & !out_ready.
- Activation, per beat (x signed 16-bit):
  - x <= -2048 gives -4096.
  - x >= 2048 gives 4096.
  - Otherwise gives x<<1 (no overflow possible in this band).
- Latency and throughput:
  - A beat accepted at edge N is presented with out_valid=1 after edge N+1, i.e. 2 register stages.
  - Sustained 1 beat/cycle while out_ready=1.
- Ordering: results leave in acceptance order; beats from two packets are never interleaved.
- Backpressure: with out_ready=0, at most 2 beats are in flight, then req_ready drops the same cycle. No beat is lost or duplicated.
- Simultaneous events: a stage-2 drain and a stage-1 load in one cycle are both allowed (full throughput).
- Reset mid-packet: lock is released and in-flight beats are discarded, with no output; the requester must restart its packet.

Decomposition:
- Shared package act_pkg holds:
  - Q4.12 constants Q_ONE=4096, Q_MINUS_ONE=-4096, Q_HALF=2048.
  - Typedef q4_12_t (signed 16-bit).
- One sub-module: the existing pwl_activation combinational block, instantiated between stage 1 and stage 2.
- Round-robin pick stays inline (a priority-rotate function in act_pkg is acceptable).

Test Plan:
- Single beat: req0 sends 1024 (last=1), out_ready=1 → after 2 cycles out_data=2048, out_id=0, out_last=1. Then sends 3000 → 4096, and -2048 → -4096.
- Round-robin: all 4 requesters hold 1-beat packets continuously from reset → out_id sequence 0,1,2,3,0,… with one beat per cycle and no gaps.
- Lock: req1 sends a 3-beat packet (100, 200, 300, last on 300) while req2 is valid → out_id 1,1,1 (data 200, 400, 600), then 2; req2 sees req_ready=0 during the packet.
- Backpressure: stream 5 beats from req3 with out_ready held 0 for 6 cycles → out_valid stays high with out_data frozen and req_ready=0 after 2 accepts. On release, all 5 beats arrive in order.
- Bubble: owner drops valid for 3 cycles mid-packet → no other grant, busy=1, packet completes intact.
- Async reset asserted mid-packet with 2 beats in flight → out_valid=0 and req_ready=0 immediately, before any clock edge. After release, a new packet from req2 is granted first, since rr_ptr was reset to 3.
